// File: rtl/mxu_matmul_seq.sv
// NxN matmul sequencer: loads A/B from scratch memory, skew-streams them into a systolic MXU,
// drains it and writes C = A*B back row-major. Optional macro MXU_ACCUM_EN adds the acc input.
module mxu_matmul_seq #(
    parameter int GRID_SIZE = 2,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 16,
    parameter int ADDR_W    = 5,
    parameter int MXU_LAT   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
`ifdef MXU_ACCUM_EN
    input  logic                                acc,
`endif
    input  logic [ADDR_W-1:0]                   base_a,
    input  logic [ADDR_W-1:0]                   base_b,
    input  logic [ADDR_W-1:0]                   base_c,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_W-1:0]                   mem_raddr,
    input  logic [DATA_W-1:0]                   mem_rdata,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_waddr,
    output logic [DATA_W-1:0]                   mem_wdata,
    output logic                                mxu_ce,
    output logic                                mxu_clr,
    output logic [GRID_SIZE*DATA_W-1:0]         west_input,
    output logic [GRID_SIZE*DATA_W-1:0]         north_input,
    input  logic [GRID_SIZE*GRID_SIZE*ACC_W-1:0] result_out
);

    localparam int N          = GRID_SIZE;
    localparam int NN         = N * N;
    localparam int STREAM_LEN = 3 * N - 2;
    localparam int MAX_CNT    = NN + STREAM_LEN + MXU_LAT + 1;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam int WIDE_W     = (ACC_W > DATA_W) ? ACC_W : DATA_W;

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(NN);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((MXU_LAT > 0) ? MXU_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] WRITE_LAST  = CNT_W'(NN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_STREAM,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [ADDR_W-1:0]  base_a_r;
    logic [ADDR_W-1:0]  base_b_r;
    logic [ADDR_W-1:0]  base_c_r;
    logic [DATA_W-1:0]  a_buf [NN];
    logic [DATA_W-1:0]  b_buf [NN];
    logic               accept;
    logic               clr_allow;

    // Results wider than memory words are cut to their low bits; narrower ones zero-extend.
    function automatic logic [DATA_W-1:0] trunc_result(input logic [ACC_W-1:0] r);
        logic [WIDE_W-1:0] w;
        w = WIDE_W'(r);
        return w[DATA_W-1:0];
    endfunction

    assign accept = (state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef MXU_ACCUM_EN
    logic acc_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 1'b0;
        end else if (accept) begin
            acc_r <= acc;
        end
    end

    assign clr_allow = !acc_r;
`else
    assign clr_allow = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            base_a_r <= base_a;
            base_b_r <= base_b;
            base_c_r <= base_c;
        end
    end

    // Read data lags the address by one cycle, so count k captures element k-1.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (state == ST_LOAD_A && cnt == CNT_W'(k + 1)) begin
                a_buf[k] <= mem_rdata;
            end
            if (state == ST_LOAD_B && cnt == CNT_W'(k + 1)) begin
                b_buf[k] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (cnt == LOAD_LAST) begin
                    state_next = ST_LOAD_B;
                    cnt_next   = '0;
                end
            end
            ST_LOAD_B: begin
                if (cnt == LOAD_LAST) begin
                    state_next = ST_STREAM;
                    cnt_next   = '0;
                end
            end
            ST_STREAM: begin
                if (cnt == STREAM_LAST) begin
                    state_next = (MXU_LAT > 0) ? ST_DRAIN : ST_WRITE;
                    cnt_next   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_next = ST_WRITE;
                    cnt_next   = '0;
                end
            end
            ST_WRITE: begin
                if (cnt == WRITE_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE) && (state != ST_DONE);
        done        = (state == ST_DONE);
        mem_raddr   = '0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        mxu_ce      = (state == ST_STREAM) || (state == ST_DRAIN);
        mxu_clr     = (state == ST_STREAM) && (cnt == '0) && clr_allow;
        west_input  = '0;
        north_input = '0;

        if (state == ST_LOAD_A && cnt < LOAD_LAST) begin
            mem_raddr = base_a_r + ADDR_W'(cnt);
        end
        if (state == ST_LOAD_B && cnt < LOAD_LAST) begin
            mem_raddr = base_b_r + ADDR_W'(cnt);
        end

        if (state == ST_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = base_c_r + ADDR_W'(cnt);
            for (int k = 0; k < NN; k++) begin
                if (cnt == CNT_W'(k)) begin
                    mem_wdata = trunc_result(result_out[k*ACC_W +: ACC_W]);
                end
            end
        end

        // Lane i carries A[i][d] and lane j carries B[d][j] at stream step t = lane + d.
        if (state == ST_STREAM) begin
            for (int l = 0; l < N; l++) begin
                for (int d = 0; d < N; d++) begin
                    if (cnt == CNT_W'(l + d)) begin
                        west_input[l*DATA_W +: DATA_W]  = a_buf[l*N + d];
                        north_input[l*DATA_W +: DATA_W] = b_buf[d*N + l];
                    end
                end
            end
        end
    end

endmodule
